// File: rtl/sev_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_pkg
// Description : Shared seven-segment definitions for the display path.
//               Holds the active-low hex segment table (gfedcba order), the
//               blank/none constants, and the encode/decode helpers used by
//               both the display driver and the readback capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package sev_seg_pkg;

  // All segments dark / no anode driven (both buses are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  // Active-low gfedcba patterns for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic       legal;
    logic [3:0] value;
  } seg_dec_t;

  // Reverse lookup of a cathode pattern; legal=0 when it is not a hex glyph.
  function automatic seg_dec_t seg_decode(input logic [6:0] ca);
    seg_dec_t r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (ca == SEG_HEX[k]) begin
        r.legal = 1'b1;
        r.value = 4'(k);
      end
    end
    return r;
  endfunction

  // Forward lookup used by the display driver.
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    return SEG_HEX[value];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sev_seg_settle.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_settle
// Description : Input sampler and glitch filter for the multiplexed display
//               bus. Registers the bus once (S), keeps the previous sample
//               (P), and counts consecutive identical samples. Emits exactly
//               one qualify pulse per settled pattern.
// Ports       : clk       - system clock
//               rst_n     - synchronous active-low reset
//               sample_i  - raw {AN, CA[, DP]} bus
//               qualify   - one-cycle pulse, settled pattern ready
//               settled   - the settled pattern (valid while qualify is high)
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg_settle #(
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_W      = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                qualify,
  output logic [SAMPLE_W-1:0] settled
);

  localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYCLES - 1);

  logic [SAMPLE_W-1:0] s_q, s_d;
  logic [SAMPLE_W-1:0] p_q, p_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                armed_q, armed_d;

  always_comb begin
    s_d     = sample_i;
    p_d     = s_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    qualify = armed_q && (cnt_q == CNT_MAX);
    if (qualify) begin
      armed_d = 1'b0;
    end
    // A change re-arms even in the qualify cycle: it is a new pattern.
    if (s_q == p_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d   = 8'd0;
      armed_d = 1'b1;
    end
  end

  // P is part of the identical run that produced the count, whereas S may
  // already hold the next pattern.
  assign settled = p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '1;
      p_q     <= '1;
      cnt_q   <= 8'd0;
      armed_q <= 1'b1;
    end else begin
      s_q     <= s_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sev_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sev_seg_capture
// Description : Readback of the shared seven-segment anode/cathode bus.
//               Recovers the hex value shown on each of the 8 digits, marks
//               digits valid/stale, pulses FRAME_DONE once every digit has
//               been captured, and flags multiple lit anodes.
// Config      : SEV_SEG_CAPTURE_DP_EN - adds DP input and DIG_DP output.
// Ports       : CLK        - system clock
//               RST_N      - synchronous active-low reset
//               AN[7:0]    - digit anodes, active-low, bit i = digit i
//               CA[6:0]    - segment cathodes, active-low, gfedcba
//               DP         - decimal point, active-low (option only)
//               DIGITS     - captured values, digit i at [4i+3:4i]
//               DIG_VALID  - digit holds a legal, non-stale capture
//               DIG_DP     - captured decimal points (option only)
//               FRAME_DONE - one-cycle pulse, all 8 digits captured
//               MULTI_ERR  - sticky, settled AN had more than one low bit
// Revision    : 1.0 - initial release
// ============================================================================
module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int STALE_CYCLES  = 1000000,
  parameter int CNT_W         = 24
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  AN,
  input  logic [6:0]  CA,
`ifdef SEV_SEG_CAPTURE_DP_EN
  input  logic        DP,
  output logic [7:0]  DIG_DP,
`endif
  output logic [31:0] DIGITS,
  output logic [7:0]  DIG_VALID,
  output logic        FRAME_DONE,
  output logic        MULTI_ERR
);

`ifdef SEV_SEG_CAPTURE_DP_EN
  localparam int SAMPLE_W = 16;
`else
  localparam int SAMPLE_W = 15;
`endif

  localparam logic [CNT_W-1:0] STALE_LIM = CNT_W'(STALE_CYCLES);

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] settled;
  logic                qualify;

`ifdef SEV_SEG_CAPTURE_DP_EN
  assign sample = {AN, CA, DP};
`else
  assign sample = {AN, CA};
`endif

  sev_seg_settle #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_W      (SAMPLE_W)
  ) u_settle (
    .clk      (CLK),
    .rst_n    (RST_N),
    .sample_i (sample),
    .qualify  (qualify),
    .settled  (settled)
  );

  logic [7:0] set_an;
  logic [6:0] set_ca;
  logic [7:0] lit;
  logic       one_lit;
  logic       many_lit;
  logic [7:0] cap_vec;
  seg_dec_t   dec;

  assign set_an   = settled[SAMPLE_W-1 -: 8];
  assign set_ca   = settled[SAMPLE_W-9 -: 7];
  assign lit      = ~set_an;
  assign one_lit  = $onehot(lit);
  assign many_lit = (set_an != AN_NONE) && !one_lit;
  assign cap_vec  = (qualify && one_lit) ? lit : 8'h00;
  assign dec      = seg_decode(set_ca);

  logic [31:0]      digits_q, digits_d;
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       seen_q, seen_d;
  logic             frame_done_q, frame_done_d;
  logic             multi_err_q, multi_err_d;
  logic [CNT_W-1:0] stale_q [8];
  logic [CNT_W-1:0] stale_d [8];
`ifdef SEV_SEG_CAPTURE_DP_EN
  logic [7:0]       dig_dp_q, dig_dp_d;
`endif

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    multi_err_d  = multi_err_q;
`ifdef SEV_SEG_CAPTURE_DP_EN
    dig_dp_d     = dig_dp_q;
`endif
    if (qualify && many_lit) begin
      multi_err_d = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      stale_d[i] = (stale_q[i] == STALE_LIM) ? stale_q[i] : stale_q[i] + CNT_W'(1);
      if (stale_d[i] == STALE_LIM) begin
        valid_d[i] = 1'b0;
      end
      // A capture overrides the aging result for this cycle.
      if (cap_vec[i]) begin
        stale_d[i] = '0;
        seen_d[i]  = 1'b1;
        valid_d[i] = dec.legal;
        if (dec.legal) begin
          digits_d[4*i +: 4] = dec.value;
        end
`ifdef SEV_SEG_CAPTURE_DP_EN
        dig_dp_d[i] = ~settled[0];
`endif
      end
    end
    // The completing capture starts no credit in the next frame.
    if (seen_d == 8'hFF) begin
      frame_done_d = 1'b1;
      seen_d       = 8'h00;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      digits_q     <= 32'h0;
      valid_q      <= 8'h00;
      seen_q       <= 8'h00;
      frame_done_q <= 1'b0;
      multi_err_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stale_q[i] <= '0;
      end
`ifdef SEV_SEG_CAPTURE_DP_EN
      dig_dp_q     <= 8'h00;
`endif
    end else begin
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      multi_err_q  <= multi_err_d;
      for (int i = 0; i < 8; i++) begin
        stale_q[i] <= stale_d[i];
      end
`ifdef SEV_SEG_CAPTURE_DP_EN
      dig_dp_q     <= dig_dp_d;
`endif
    end
  end

  assign DIGITS     = digits_q;
  assign DIG_VALID  = valid_q;
  assign FRAME_DONE = frame_done_q;
  assign MULTI_ERR  = multi_err_q;
`ifdef SEV_SEG_CAPTURE_DP_EN
  assign DIG_DP     = dig_dp_q;
`endif

endmodule
`default_nettype wire
